pc_fetch_ctrl: RTL and testbench

Sequencer for the program counter register and the instruction-memory fetch port.
- Decides each cycle whether the PC register is written and with what value: sequential +4, branch/jump redirect, or trap vector.
- Runs a single-outstanding req/ack fetch handshake and buffers one fetched instruction for decode.
- Sits between the PC register, instruction memory, and the decode/execute stages of the core.

---
 rtl/pc_fetch_pkg.sv | 24 ++
 rtl/fetch_buf.sv | 48 ++++
 rtl/pc_fetch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_pkg
// Description : Shared types and constants for the PC / instruction-fetch
//               sequencer (state encoding, instruction width, PC step).
// Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

  // Width of one fetched instruction word
  localparam int INSTR_W = 32;

  // Byte distance between sequential instructions
  localparam int PC_STEP = 4;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf
// Description : One-entry holding register for a fetched instruction and the
//               address it came from. Clear drops the entry, load fills it.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buf
  import pc_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               res,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [XLEN-1:0]    pc_d,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [XLEN-1:0]    r_pc;

  // Entry register: clear wins so a flush can never leave a stale entry valid
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_instr <= instr_d;
      r_pc    <= pc_d;
    end
  end

  assign valid = r_valid;
  assign instr = r_instr;
  assign pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_ctrl
// Description : Program-counter write sequencer and single-outstanding
//               instruction fetch controller with a one-entry fetch buffer.
//               Optional build macro PC_MISALIGN_CHECK_EN turns misaligned
//               redirect targets into traps and pulses fetch_misalign.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               res,
  input  logic [XLEN-1:0]    pc_q,
  output logic               pc_write,
  output logic [XLEN-1:0]    pc_next,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [XLEN-1:0]    if_pc,
  input  logic               if_ready,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               trap_valid,
  output logic               fetch_misalign
);

  fetch_state_t    r_state, w_state_d;
  logic            r_squash, w_squash_d;
  logic [XLEN-1:0] r_req_addr, w_req_addr_d;
  logic            w_pc_write;
  logic [XLEN-1:0] w_pc_next;
  logic            w_buf_load;
  logic            w_buf_clear;
  logic            w_flush;
  logic            w_misalign;
  logic [XLEN-1:0] w_tgt;

`ifdef PC_MISALIGN_CHECK_EN
  logic r_misalign;

  // A non-trap redirect to a non-word address is promoted to a trap
  assign w_misalign = redirect_valid & ~trap_valid & (redirect_pc[1:0] != 2'b00);

  // Report the promoted redirect one cycle after it is acted on
  always_ff @(posedge clk or posedge res) begin
    if (res) r_misalign <= 1'b0;
    else     r_misalign <= w_misalign & (r_state != IDLE);
  end

  assign fetch_misalign = r_misalign;
`else
  assign w_misalign     = 1'b0;
  assign fetch_misalign = 1'b0;
`endif

  // Trap (real or promoted) beats a plain redirect
  assign w_flush = trap_valid | redirect_valid;
  assign w_tgt   = (trap_valid | w_misalign) ? TRAP_VEC : redirect_pc;

  // State, squash flag and outstanding request address
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state    <= IDLE;
      r_squash   <= 1'b0;
      r_req_addr <= '0;
    end else begin
      r_state    <= w_state_d;
      r_squash   <= w_squash_d;
      r_req_addr <= w_req_addr_d;
    end
  end

  // Next-state, next-PC mux and buffer control
  always_comb begin
    w_state_d    = r_state;
    w_squash_d   = r_squash;
    w_req_addr_d = r_req_addr;
    w_pc_write   = 1'b0;
    w_pc_next    = '0;
    w_buf_load   = 1'b0;
    w_buf_clear  = 1'b0;
    case (r_state)
      IDLE: begin
        w_pc_write   = 1'b1;
        w_pc_next    = RESET_VEC;
        w_req_addr_d = RESET_VEC;
        w_state_d    = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          if (r_squash || w_flush) begin
            // Response belongs to an abandoned path: drop it and re-issue
            w_squash_d   = 1'b0;
            w_req_addr_d = w_flush ? w_tgt : pc_q;
            if (w_flush) begin
              w_pc_write = 1'b1;
              w_pc_next  = w_tgt;
            end
          end else begin
            w_buf_load = 1'b1;
            w_pc_write = 1'b1;
            w_pc_next  = pc_q + XLEN'(PC_STEP);
            w_state_d  = HOLD;
          end
        end else if (w_flush) begin
          // Request in flight cannot be withdrawn; remember to drop its data
          w_pc_write = 1'b1;
          w_pc_next  = w_tgt;
          w_squash_d = 1'b1;
        end
      end
      HOLD: begin
        if (w_flush) begin
          w_buf_clear  = 1'b1;
          w_pc_write   = 1'b1;
          w_pc_next    = w_tgt;
          w_req_addr_d = w_tgt;
          w_state_d    = FETCH;
        end else if (if_ready) begin
          w_buf_clear  = 1'b1;
          w_req_addr_d = pc_q;
          w_state_d    = FETCH;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  // Keep the PC write port quiet for the whole time reset is held
  assign pc_write  = w_pc_write & ~res;
  assign pc_next   = res ? '0 : w_pc_next;
  assign imem_req  = (r_state == FETCH);
  assign imem_addr = r_req_addr;

  fetch_buf #(
    .XLEN (XLEN)
  ) u_fetch_buf (
    .clk     (clk),
    .res     (res),
    .load    (w_buf_load),
    .clear   (w_buf_clear),
    .instr_d (imem_rdata),
    .pc_d    (r_req_addr),
    .valid   (if_valid),
    .instr   (if_instr),
    .pc      (if_pc)
  );

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_ctrl
// Description : Directed self-checking bench for pc_fetch_ctrl, including an
//               external PC register driven by pc_write/pc_next. Expectations
//               for PC_MISALIGN_CHECK_EN follow the same macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        res;
  logic [31:0] pc_q;
  logic        pc_write;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic        fetch_misalign;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] I0 = 32'h0010_0093;
  localparam logic [31:0] I1 = 32'h0020_0113;
  localparam logic [31:0] I2 = 32'h0030_0193;
  localparam logic [31:0] I3 = 32'h0040_0213;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

`ifdef PC_MISALIGN_CHECK_EN
  localparam logic [31:0] MIS_TGT  = 32'h0000_0100;
  localparam logic [31:0] MIS_FLAG = 32'd1;
`else
  localparam logic [31:0] MIS_TGT  = 32'h0000_0042;
  localparam logic [31:0] MIS_FLAG = 32'd0;
`endif

  pc_fetch_ctrl #(
    .XLEN      (32),
    .RESET_VEC (32'h0000_0000),
    .TRAP_VEC  (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .res            (res),
    .pc_q           (pc_q),
    .pc_write       (pc_write),
    .pc_next        (pc_next),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The PC register the controller sequences
  always @(posedge clk or posedge res) begin
    if (res)           pc_q <= 32'h0;
    else if (pc_write) pc_q <= pc_next;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to the next negedge, where inputs are changed for the coming posedge
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    res = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; trap_valid = 1'b0;

    // Reset state
    step(); step(); #1;
    chk("rst_pc_write", {31'b0, pc_write}, 32'd0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);

    // Test 1: IDLE loads reset vector, then zero-wait fetches 0x0, 0x4, 0x8
    res = 1'b0; #1;
    chk("idle_pc_write", {31'b0, pc_write}, 32'd1);
    chk("idle_pc_next", pc_next, 32'h0);
    step(); imem_ack = 1'b1; imem_rdata = I0; #1;
    chk("f0_req", {31'b0, imem_req}, 32'd1);
    chk("f0_addr", imem_addr, 32'h0);
    chk("f0_pc_next", pc_next, 32'h4);
    step(); imem_ack = 1'b0; if_ready = 1'b1; #1;
    chk("h0_if_valid", {31'b0, if_valid}, 32'd1);
    chk("h0_if_instr", if_instr, I0);
    chk("h0_if_pc", if_pc, 32'h0);
    chk("h0_req", {31'b0, imem_req}, 32'd0);
    chk("h0_pc_write", {31'b0, pc_write}, 32'd0);
    step(); if_ready = 1'b0; imem_ack = 1'b1; imem_rdata = I1; #1;
    chk("f1_addr", imem_addr, 32'h4);
    chk("f1_if_valid", {31'b0, if_valid}, 32'd0);
    chk("f1_pc_next", pc_next, 32'h8);
    step(); imem_ack = 1'b0; #1;
    chk("h1_if_pc", if_pc, 32'h4);
    chk("h1_if_instr", if_instr, I1);

    // Test 2: decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      chk("stall_if_valid", {31'b0, if_valid}, 32'd1);
      chk("stall_if_pc", if_pc, 32'h4);
      chk("stall_if_instr", if_instr, I1);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_pc_q", pc_q, 32'h8);
      chk("stall_pc_write", {31'b0, pc_write}, 32'd0);
      step(); #1;
    end
    if_ready = 1'b1;
    step(); if_ready = 1'b0; #1;
    chk("f2_addr", imem_addr, 32'h8);
    chk("f2_req", {31'b0, imem_req}, 32'd1);

    // Test 3: redirect to 0x40 while request at 0x8 waits for ack
    redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    chk("rd_pc_write", {31'b0, pc_write}, 32'd1);
    chk("rd_pc_next", pc_next, 32'h40);
    step(); redirect_valid = 1'b0; #1;
    chk("rd_w1_addr", imem_addr, 32'h8);
    chk("rd_w1_req", {31'b0, imem_req}, 32'd1);
    chk("rd_w1_pc_write", {31'b0, pc_write}, 32'd0);
    step(); #1;
    chk("rd_w2_addr", imem_addr, 32'h8);
    step(); imem_ack = 1'b1; imem_rdata = JUNK; #1;
    chk("rd_ack_pc_write", {31'b0, pc_write}, 32'd0);
    step(); imem_ack = 1'b0; #1;
    chk("rd_discard_valid", {31'b0, if_valid}, 32'd0);
    chk("rd_new_addr", imem_addr, 32'h40);
    chk("rd_new_req", {31'b0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = I2; #1;
    chk("rd_f_pc_next", pc_next, 32'h44);
    step(); imem_ack = 1'b0; #1;
    chk("rd_if_pc", if_pc, 32'h40);
    chk("rd_if_instr", if_instr, I2);

    // Test 4: trap and redirect together in HOLD, decode ready as well
    trap_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80; if_ready = 1'b1; #1;
    chk("tr_pc_write", {31'b0, pc_write}, 32'd1);
    chk("tr_pc_next", pc_next, 32'h100);
    step(); trap_valid = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0; #1;
    chk("tr_if_valid", {31'b0, if_valid}, 32'd0);
    chk("tr_addr", imem_addr, 32'h100);
    chk("tr_pc_q", pc_q, 32'h100);

    // Test 5: redirect to last word (same-cycle ack is dropped), then wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = JUNK; #1;
    chk("wr_rd_pc_next", pc_next, 32'hFFFF_FFFC);
    step(); redirect_valid = 1'b0; imem_ack = 1'b0; #1;
    chk("wr_drop_valid", {31'b0, if_valid}, 32'd0);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = I3; #1;
    chk("wr_pc_next", pc_next, 32'h0);
    step(); imem_ack = 1'b0; #1;
    chk("wr_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wr_pc_q", pc_q, 32'h0);

    // Test 6: misaligned redirect from HOLD
    redirect_valid = 1'b1; redirect_pc = 32'h42; if_ready = 1'b1; #1;
    chk("mis_pc_next", pc_next, MIS_TGT);
    chk("mis_flag_pre", {31'b0, fetch_misalign}, 32'd0);
    step(); redirect_valid = 1'b0; if_ready = 1'b0; #1;
    chk("mis_flag", {31'b0, fetch_misalign}, MIS_FLAG);
    chk("mis_addr", imem_addr, MIS_TGT);
    step(); #1;
    chk("mis_flag_post", {31'b0, fetch_misalign}, 32'd0);

    // Reset mid-request abandons it immediately
    chk("mr_req_pre", {31'b0, imem_req}, 32'd1);
    res = 1'b1; #1;
    chk("mr_req", {31'b0, imem_req}, 32'd0);
    chk("mr_addr", imem_addr, 32'h0);
    chk("mr_pc_write", {31'b0, pc_write}, 32'd0);
    step(); res = 1'b0;
    step(); #1;
    chk("mr_restart_addr", imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
